io_uart_ctrl: RTL
=================

Name: io_uart_ctrl

Overview:
Parametrised UART device controller for one slot of the CPU I/O decoder. It uses the same slot interface as the LED, switch and button controllers: we, reg_sel[1:0], cs, 16-bit in/out. It adds TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and FIFO level reporting. It replaces the unimplemented UART slot on device 1 of the board top level.

Parameters:
DIV_RESET, 868, baud divisor after reset, in clk cycles per bit (868 gives 115200 baud at 100 MHz).
FIFO_AW, 4, log2 of depth for each FIFO; TX and RX depth = 2**FIFO_AW.
SYNC_STAGES, 2, flip-flops in the rx input synchroniser (minimum 2).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
we  in  1  write strobe; acts only when cs=1.
reg_sel  in  2  register select.
cs  in  1  chip select from the I/O decoder.
in  in  16  write data from the CPU.
out  out  16  read data; combinational from reg_sel when cs=1, else 16'h0000.
rx  in  1  serial input (asynchronous).
tx  out  1  serial output; idle high.

Behaviour:
- Register map. Every write acts for each clk cycle that cs&we is high, so the CPU issues one-cycle strobes.
  - reg 0 write: push in[7:0] into the TX FIFO. Dropped if TX FIFO is full.
  - reg 0 read: {7'b0, rx_nonempty, rx_head[7:0]}. Reading does not pop.
  - reg 1 write, command bits (any combination in one cycle):
    - in[0]: pop RX; ignored if empty.
    - in[1]: flush TX FIFO; a frame already in flight completes.
    - in[2]: flush RX FIFO.
    - in[3]: clear sticky errors.
  - reg 1 read, status: [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy (shifter active), [5] overrun, [6] frame_err, [7] parity_err, [15:8] 0.
  - reg 2: baud divisor, read/write, 16 bits. Writes below 2 are stored as 2.
  - reg 3 read: {rx_count[7:0], tx_count[7:0]}, zero-extended. reg 3 writes are ignored.
- Reset values: tx=1; both FIFOs empty; divisor=DIV_RESET; error flags=0; TX and RX FSMs in IDLE; out=0 while cs=0.
- Baud timing:
  - One bit period = divisor clk cycles.
  - The divisor is latched by each FSM at the start of a frame, so a mid-frame write takes effect on the next frame.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - In IDLE with TX FIFO non-empty: pop, and tx goes low on the next cycle.
  - Frame length = 10 bit periods (11 with parity).
  - Back-to-back frames have no extra idle gap.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, running on the synchronised rx.
  - IDLE: a low level on synced rx enters START.
  - START: samples at divisor/2 (integer division). High = false start, return to IDLE with nothing pushed.
  - DATA and STOP: sample every divisor cycles thereafter.
  - Stop bit sampled low: set frame_err; the byte is still pushed.
  - RX FIFO full at push time: byte dropped, set overrun.
  - After STOP, returns to IDLE at the stop-bit sample point.
- FIFOs:
  - Push and pop in the same cycle: both occur; count unchanged. Also allowed when full or empty, except that a push to a full FIFO with no pop is dropped.
  - Counts are 0..2**FIFO_AW inclusive.
  - A flush in the same cycle as a push: flush wins; result is empty.
- Sticky errors:
  - Set on event, cleared only by in[3] or reset.
  - Set and clear in the same cycle: set wins.
- Reset mid-frame: tx returns high on the next cycle; any partial RX byte is discarded.

Optional Feature:
UART_PARITY_EN.
- Defined: an even parity bit is inserted after D7 on TX and checked on RX. A mismatch sets parity_err; the byte is still pushed.
- Undefined: no parity bit on either side; status[7] reads 0.

Test Plan:
1. Reset then read reg 1 -> 16'h0004; read reg 2 -> DIV_RESET; tx=1.
2. Divisor=16; write 0x55 to reg 0 -> tx low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles. Status bit4 is set during the frame.
3. Divisor=16; loop tx to rx; write 0xA3, 0x0F -> reg 3 reads 16'h0200 after both frames. Reg 0 reads 16'h01A3; pop; reg 0 reads 16'h010F.
4. FIFO_AW=2; drive 5 frames into rx without popping -> rx_count=4, overrun=1. Write in[3] to reg 1 -> status bit5 = 0.
5. Drive rx with a stop bit of 0 -> frame_err=1 and the byte is present. Drive a 4-cycle low glitch with divisor=16 -> nothing pushed.
6. Write 3 bytes, then flush TX during the first frame -> that frame completes, tx_count=0, and tx stays high afterwards.

Source files
------------

// File: rtl/io_uart_ctrl.sv
// UART slot controller: TX/RX FIFOs, programmable baud divisor, sticky errors.
// Optional even parity on both directions when UART_PARITY_EN is defined.
module uart_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(2**AW));
  // simultaneous push/pop is always honoured, even at the full/empty edges
  assign pop_ok  = pop & (~empty | push);
  assign push_ok = push & (~full | pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk)
    if (push_ok && !flush) mem[wp] <= wdata;
endmodule

module io_uart_ctrl #(
  parameter int DIV_RESET   = 868,
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic        cs,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        rx,
  output logic        tx
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

  logic        wr, cmd;
  logic        tx_push, tx_pop, tx_flush, rx_pop, rx_flush, err_clr;
  logic [7:0]  tx_rdata, rx_rdata;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [15:0] divisor;
  logic        ov, fe, pe;

  assign wr       = cs & we;
  assign cmd      = wr && reg_sel == 2'd1;
  assign tx_push  = wr && reg_sel == 2'd0;
  assign tx_flush = cmd & in[1];
  assign rx_pop   = cmd & in[0];
  assign rx_flush = cmd & in[2];
  assign err_clr  = cmd & in[3];

  always_ff @(posedge clk)
    if (reset) divisor <= 16'(DIV_RESET);
    else if (wr && reg_sel == 2'd2) divisor <= (in < 16'd2) ? 16'd2 : in;

  // ---------------- TX ----------------
  st_t         ts;
  logic [15:0] tdiv, tcnt;
  logic [2:0]  tbit;
  logic [7:0]  tsh;
  logic        tend, tx_busy;
`ifdef UART_PARITY_EN
  logic        tpar;
`endif

  assign tend    = (tcnt == tdiv - 16'd1);
  assign tx_busy = (ts != S_IDLE);
  // load the next byte straight from STOP so frames run back-to-back
  assign tx_pop  = !tx_empty && (ts == S_IDLE || (ts == S_STOP && tend));

  always_ff @(posedge clk) begin
    if (reset) begin
      ts   <= S_IDLE;
      tx   <= 1'b1;
      tdiv <= 16'd2;
      tcnt <= '0;
      tbit <= '0;
      tsh  <= '0;
`ifdef UART_PARITY_EN
      tpar <= 1'b0;
`endif
    end else if (tx_pop) begin
      ts   <= S_START;
      tx   <= 1'b0;
      tdiv <= divisor;
      tcnt <= '0;
      tsh  <= tx_rdata;
`ifdef UART_PARITY_EN
      tpar <= ^tx_rdata;
`endif
    end else if (ts == S_IDLE) begin
      tx <= 1'b1;
    end else if (!tend) begin
      tcnt <= tcnt + 16'd1;
    end else begin
      tcnt <= '0;
      case (ts)
        S_START: begin ts <= S_DATA; tx <= tsh[0]; tbit <= '0; end
        S_DATA:
          if (tbit == 3'd7) begin
`ifdef UART_PARITY_EN
            ts <= S_PAR; tx <= tpar;
`else
            ts <= S_STOP; tx <= 1'b1;
`endif
          end else begin
            tsh  <= tsh >> 1;
            tx   <= tsh[1];
            tbit <= tbit + 3'd1;
          end
        S_PAR:   begin ts <= S_STOP; tx <= 1'b1; end
        default: begin ts <= S_IDLE; tx <= 1'b1; end
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [SYNC_STAGES-1:0] rsync;
  logic        rxs;
  st_t         rs;
  logic [15:0] rdiv, rcnt;
  logic [2:0]  rbit;
  logic [7:0]  rsh;
  logic        rpush, rfe, rpe;
`ifdef UART_PARITY_EN
  logic        rpar_bad;
`endif

  assign rxs = rsync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rsync <= '1;
      rs    <= S_IDLE;
      rdiv  <= 16'd2;
      rcnt  <= '0;
      rbit  <= '0;
      rsh   <= '0;
      rpush <= 1'b0;
      rfe   <= 1'b0;
      rpe   <= 1'b0;
`ifdef UART_PARITY_EN
      rpar_bad <= 1'b0;
`endif
    end else begin
      rsync <= {rsync[SYNC_STAGES-2:0], rx};
      rpush <= 1'b0;
      rfe   <= 1'b0;
      rpe   <= 1'b0;
      case (rs)
        S_IDLE:
          if (!rxs) begin rs <= S_START; rcnt <= 16'd1; rdiv <= divisor; end
        S_START:
          if (rcnt == (rdiv >> 1)) begin
            rs   <= rxs ? S_IDLE : S_DATA;
            rcnt <= 16'd1;
            rbit <= '0;
          end else rcnt <= rcnt + 16'd1;
        default:
          if (rcnt != rdiv) rcnt <= rcnt + 16'd1;
          else begin
            rcnt <= 16'd1;
            case (rs)
              S_DATA: begin
                rsh <= {rxs, rsh[7:1]};
                rbit <= rbit + 3'd1;
`ifdef UART_PARITY_EN
                if (rbit == 3'd7) rs <= S_PAR;
`else
                if (rbit == 3'd7) rs <= S_STOP;
`endif
              end
`ifdef UART_PARITY_EN
              S_PAR: begin rpar_bad <= rxs ^ (^rsh); rs <= S_STOP; end
`endif
              default: begin
                rs    <= S_IDLE;
                rpush <= 1'b1;
                rfe   <= ~rxs;
`ifdef UART_PARITY_EN
                rpe   <= rpar_bad;
`endif
              end
            endcase
          end
      endcase
    end
  end

  uart_fifo #(.AW(FIFO_AW)) u_txf (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(in[7:0]), .rdata(tx_rdata), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );

  uart_fifo #(.AW(FIFO_AW)) u_rxf (
    .clk(clk), .reset(reset), .push(rpush), .pop(rx_pop), .flush(rx_flush),
    .wdata(rsh), .rdata(rx_rdata), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );

  // set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ov <= 1'b0;
      fe <= 1'b0;
    end else begin
      ov <= (ov & ~err_clr) | (rpush & rx_full & ~rx_pop & ~rx_flush);
      fe <= (fe & ~err_clr) | rfe;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk)
    if (reset) pe <= 1'b0;
    else       pe <= (pe & ~err_clr) | rpe;
`else
  assign pe = 1'b0;
`endif

  always_comb begin
    out = '0;
    if (cs)
      case (reg_sel)
        2'd0: out = {7'b0, ~rx_empty, rx_rdata};
        2'd1: out = {8'b0, pe, fe, ov, tx_busy, tx_full, tx_empty, rx_full, ~rx_empty};
        2'd2: out = divisor;
        default: out = {8'(rx_count), 8'(tx_count)};
      endcase
  end
endmodule
